// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage widths, NOP encoding and fetch FSM states.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN, S_HALT} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-2 synchronous FIFO with push/pop/flush and occupancy count.
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop = i_pop & (r_cnt != '0);
  assign w_push = i_push & ((r_cnt != (AW+1)'(DEPTH)) | w_pop);
  assign o_data = r_mem[r_rd];
  assign o_count = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, in-order imem requester and decode-side instruction buffer.
// FETCH_MISALIGN_CHECK_EN enables the sticky misaligned-redirect flag and HALT state.
module instr_fetch_unit #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_req_valid,
  input  logic                           imem_req_ready,
  output logic [XLEN-1:0]                imem_req_addr,
  input  logic                           imem_rsp_valid,
  input  logic [riscv_pkg::INSTR_W-1:0]  imem_rsp_data,
  input  logic                           redirect_valid,
  input  logic [XLEN-1:0]                redirect_pc,
  output logic                           id_valid,
  input  logic                           id_ready,
  output logic [riscv_pkg::INSTR_W-1:0]  id_instr,
  output logic [XLEN-1:0]                id_pc,
  output logic                           fetch_misalign
);
  import riscv_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_haddr, w_rpc, w_tag;
  logic [INSTR_W+XLEN-1:0] w_head;
  logic [CW-1:0] r_drop, w_drop_nxt, w_out, w_cnt;
  logic r_hold, r_hstale, w_acc, w_can, w_push, w_halt, w_misal;
  assign w_rpc = redirect_pc & ~XLEN'(3);
  assign w_halt = r_state == S_HALT;
  assign w_can = (r_state == S_RUN) && ((w_out + w_cnt) < CW'(FIFO_DEPTH));
  assign imem_req_valid = r_hold | w_can;
  // A request pending across a redirect keeps its old address until accepted.
  assign imem_req_addr = r_hstale ? r_haddr : r_pc;
  assign w_acc = imem_req_valid & imem_req_ready;
  assign w_push = imem_rsp_valid & (r_drop == '0) & ~redirect_valid & ~w_halt;
  // Everything in flight or still pending at a redirect is stale.
  assign w_drop_nxt = redirect_valid ? w_out + CW'(imem_req_valid) - CW'(imem_rsp_valid) :
                      (imem_rsp_valid && r_drop != '0) ? r_drop - CW'(1) : r_drop;
  assign id_valid = w_cnt != '0;
  assign id_instr = id_valid ? w_head[XLEN +: INSTR_W] : NOP_INSTR;
  assign id_pc = id_valid ? w_head[XLEN-1:0] : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misal;
  assign w_misal = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = r_misal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misal <= 1'b0;
    else if (w_misal) r_misal <= 1'b1;
  end
`else
  assign w_misal = 1'b0;
  assign fetch_misalign = 1'b0;
`endif
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_halt ? S_HALT :
                  w_misal ? S_HALT :
                  redirect_valid ? ((w_drop_nxt != '0) ? S_DRAIN : S_RUN) :
                  (r_state == S_BOOT) ? S_RUN :
                  (r_state == S_DRAIN && w_drop_nxt == '0) ? S_RUN : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_BOOT;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_haddr <= RESET_PC;
      r_hold <= 1'b0;
      r_hstale <= 1'b0;
      r_drop <= '0;
    end else begin
      r_pc <= redirect_valid ? w_rpc : (w_acc & ~r_hstale) ? r_pc + XLEN'(4) : r_pc;
      r_hold <= imem_req_valid & ~imem_req_ready;
      r_hstale <= (r_hstale | redirect_valid) & imem_req_valid & ~imem_req_ready;
      if (!r_hstale) r_haddr <= r_pc;
      r_drop <= w_drop_nxt;
    end
  end
  fetch_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH)) u_tag (
    .clk(clk), .rst(rst), .i_push(w_acc), .i_data(imem_req_addr), .i_pop(imem_rsp_valid),
    .i_flush(1'b0), .o_data(w_tag), .o_count(w_out)
  );
  fetch_fifo #(.W(INSTR_W + XLEN), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk), .rst(rst), .i_push(w_push), .i_data({imem_rsp_data, w_tag}),
    .i_pop(id_valid & id_ready), .i_flush(redirect_valid | w_halt), .o_data(w_head), .o_count(w_cnt)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: memory model plus scoreboard of expected {pc, instr} deliveries.
module tb_instr_fetch_unit;
  import riscv_pkg::*;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h100;
  typedef struct {logic [31:0] addr; logic stale; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready, fetch_misalign;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc;
  req_t mq[$];
  exp_t sb[$];
  logic [31:0] acc_log[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, lat = 1, n_drop = 0;
  logic g_ready = 1, g_idr = 1, g_redir = 0, m_hs = 0, prev_hold = 0;
  logic [31:0] g_rpc = 0, m_pc = RPC, m_ha = 0;
  always #5 clk = ~clk;
  instr_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .fetch_misalign(fetch_misalign)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h13570013;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic rv, rs, acc;
    logic [31:0] ra, ea;
    @(negedge clk);
    rv = 0; rs = 0; ra = 0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1; rs = mq[0].stale; ra = mq[0].addr;
      mq.delete(0);
    end
    imem_rsp_valid = rv;
    imem_rsp_data = rv ? mem_word(ra) : 32'h0;
    imem_req_ready = g_ready;
    redirect_valid = g_redir;
    redirect_pc = g_rpc;
    id_ready = g_idr;
    #1;
    check("id_valid", id_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("id_pc", id_pc, sb[0].pc);
      check("id_instr", id_instr, sb[0].instr);
      if (g_idr) sb.delete(0);
    end
    if (prev_hold) check("req_hold", imem_req_valid, 1);
    ea = m_hs ? m_ha : m_pc;
    if (imem_req_valid) check("req_addr", imem_req_addr, ea);
    acc = imem_req_valid & g_ready;
    if (acc) begin
      mq.push_back('{addr: ea, stale: m_hs, due: cyc + lat});
      if (!m_hs && !g_redir) acc_log.push_back(imem_req_addr);
      if (!m_hs) m_pc = m_pc + 4;
      m_hs = 0;
      check("inflight", mq.size() <= DEPTH, 1);
    end else if (imem_req_valid && g_redir && !m_hs) begin
      m_hs = 1; m_ha = m_pc;
    end
    prev_hold = imem_req_valid & ~g_ready;
    if (rv && (rs || g_redir)) n_drop++;
    if (rv && !rs && !g_redir) sb.push_back('{pc: ra, instr: mem_word(ra)});
    if (g_redir) begin
      foreach (mq[i]) mq[i].stale = 1;
      sb.delete();
      m_pc = g_rpc & ~32'h3;
    end
    cyc++;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic redir(input logic [31:0] a);
    g_redir = 1; g_rpc = a;
    step();
    g_redir = 0;
  endtask
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!id_valid && k < 30) begin step(); k++; end
    if (!id_valid) check(tag, id_valid, 1);
  endtask
  task automatic do_reset();
    rst = 1;
    imem_rsp_valid = 0; redirect_valid = 0; imem_req_ready = 1; id_ready = 1;
    redirect_pc = 0; imem_rsp_data = 0;
    mq.delete(); sb.delete(); acc_log.delete();
    m_pc = RPC; m_hs = 0; prev_hold = 0; g_redir = 0; g_ready = 1; g_idr = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, NOP_INSTR);
    check("rst_id_pc", id_pc, 0);
    check("rst_misalign", fetch_misalign, 0);
    rst = 0;
  endtask
  initial begin
    int k;
    do_reset();
    lat = 1; k = 0;
    while (!id_valid && k < 10) begin step(); k++; end
    check("first_valid_lat", k, 3);
    run(6);
    if (acc_log.size() < 3) check("boot_acc_cnt", acc_log.size(), 3);
    else begin
      check("boot_addr0", acc_log[0], 32'h100);
      check("boot_addr1", acc_log[1], 32'h104);
      check("boot_addr2", acc_log[2], 32'h108);
    end
    g_idr = 0;
    run(10);
    check("stall_full", sb.size(), DEPTH);
    g_idr = 1;
    run(8);
    lat = 3; k = 0;
    while (mq.size() != 2 && k < 20) begin step(); k++; end
    check("two_outstanding", mq.size(), 2);
    n_drop = 0;
    redir(32'h200);
    wait_valid("redir_timeout");
    check("redir_pc", id_pc, 32'h200);
    check("dropped", n_drop, 2);
    run(6);
    lat = 1;
    g_ready = 0;
    run(2);
    check("hold_valid", imem_req_valid, 1);
    redir(32'h300);
    run(2);
    g_ready = 1;
    wait_valid("hold_timeout");
    check("hold_redir_pc", id_pc, 32'h300);
    run(4);
    acc_log.delete();
    redir(32'hFFFFFFFC);
    run(8);
    if (acc_log.size() < 2) check("wrap_cnt", acc_log.size(), 2);
    else begin
      check("wrap_addr0", acc_log[0], 32'hFFFFFFFC);
      check("wrap_addr1", acc_log[1], 32'h0);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    redir(32'h202);
    for (int i = 0; i < 8; i++) begin
      step();
      check("halt_no_req", imem_req_valid, 0);
    end
    check("misalign_set", fetch_misalign, 1);
`else
    acc_log.delete();
    redir(32'h202);
    wait_valid("align_timeout");
    check("align_pc", id_pc, 32'h200);
    check("misalign_off", fetch_misalign, 0);
    if (acc_log.size() > 0) check("align_addr", acc_log[0], 32'h200);
`endif
    lat = 3;
    run(4);
    do_reset();
    lat = 1;
    run(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
